// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that time-shares one combinational ALU between two
// valid/ready requesters; one operation in flight, result returned per requester.
module alu_share_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_result,
    output logic             rsp0_zero,
    output logic             rsp0_sign,
    output logic             rsp0_err,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_result,
    output logic             rsp1_zero,
    output logic             rsp1_sign,
    output logic             rsp1_err,
    output logic [WIDTH-1:0] alu_srca,
    output logic [WIDTH-1:0] alu_srcb,
    output logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    input  logic             alu_sign,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t                      state, state_nxt;
    logic                        last_grant;
    logic                        owner;
    logic                        err_q;
    logic [1:0]                  req_vld;
    logic [1:0]                  rsp_rdy;
    logic [1:0]                  grant;
    logic [1:0]                  rsp_vld;
    logic                        accept;
    logic                        hshake;
    logic [1:0][WIDTH-1:0]       res_q;
    logic [1:0]                  zero_q;
    logic [1:0]                  sign_q;

    assign req_vld = {req1_valid, req0_valid};
    assign rsp_rdy = {rsp1_ready, rsp0_ready};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Grant is gated by reset so no ready can leak out while reset is held.
    always_comb begin
        state_nxt = state;
        grant     = 2'b00;
        accept    = 1'b0;
        hshake    = 1'b0;
        case (state)
            IDLE: begin
                if (!reset) begin
                    if (req_vld == 2'b11) grant = last_grant ? 2'b01 : 2'b10;
                    else                  grant = {req_vld[1] & ~req_vld[0], req_vld[0]};
                end
                if (|grant) begin
                    accept    = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                if (rsp_rdy[owner]) begin
                    hshake    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= 1'b1;
            owner      <= 1'b0;
            err_q      <= 1'b0;
            alu_srca   <= '0;
            alu_srcb   <= '0;
            alu_ctrl   <= 3'b000;
            res_q      <= '0;
            zero_q     <= 2'b00;
            sign_q     <= 2'b00;
        end else begin
            if (accept) begin
                owner    <= grant[1];
                alu_srca <= grant[1] ? req1_a  : req0_a;
                alu_srcb <= grant[1] ? req1_b  : req0_b;
                alu_ctrl <= grant[1] ? req1_op : req0_op;
                err_q    <= (grant[1] ? req1_op : req0_op) == 3'b011;
            end
            if (state == EXEC) begin
                res_q[owner]  <= alu_result;
                zero_q[owner] <= alu_zero;
                sign_q[owner] <= alu_sign;
            end
            if (hshake) last_grant <= owner;
        end
    end

    assign rsp_vld[0] = (state == RESP) && !owner;
    assign rsp_vld[1] = (state == RESP) &&  owner;

    assign req0_ready  = grant[0];
    assign req1_ready  = grant[1];
    assign rsp0_valid  = rsp_vld[0];
    assign rsp1_valid  = rsp_vld[1];
    assign rsp0_result = res_q[0];
    assign rsp1_result = res_q[1];
    assign rsp0_zero   = zero_q[0];
    assign rsp1_zero   = zero_q[1];
    assign rsp0_sign   = sign_q[0];
    assign rsp1_sign   = sign_q[1];
    assign rsp0_err    = rsp_vld[0] & err_q;
    assign rsp1_err    = rsp_vld[1] & err_q;
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU on the alu_* ports.
module tb_alu_share_arbiter;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             req0_valid, req0_ready, req1_valid, req1_ready;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]       req0_op, req1_op;
    logic             rsp0_valid, rsp0_ready, rsp0_zero, rsp0_sign, rsp0_err;
    logic             rsp1_valid, rsp1_ready, rsp1_zero, rsp1_sign, rsp1_err;
    logic [WIDTH-1:0] rsp0_result, rsp1_result;
    logic [WIDTH-1:0] alu_srca, alu_srcb, alu_result;
    logic [2:0]       alu_ctrl;
    logic             alu_zero, alu_sign, busy;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
        .rsp0_zero(rsp0_zero), .rsp0_sign(rsp0_sign), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
        .rsp1_zero(rsp1_zero), .rsp1_sign(rsp1_sign), .rsp1_err(rsp1_err),
        .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_sign(alu_sign),
        .busy(busy)
    );

    // Reference ALU: illegal code 011 yields zero.
    always_comb begin
        case (alu_ctrl)
            3'b000:  alu_result = alu_srca + alu_srcb;
            3'b001:  alu_result = alu_srca << alu_srcb[4:0];
            3'b010:  alu_result = alu_srca - alu_srcb;
            3'b100:  alu_result = alu_srca ^ alu_srcb;
            3'b101:  alu_result = alu_srca >> alu_srcb[4:0];
            3'b110:  alu_result = alu_srca | alu_srcb;
            3'b111:  alu_result = alu_srca & alu_srcb;
            default: alu_result = '0;
        endcase
    end
    assign alu_zero = (alu_result == '0);
    assign alu_sign = alu_result[WIDTH-1];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        req0_valid = 1'b1; req0_a = '0; req0_b = '0; req0_op = 3'b000;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = 3'b000;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;

        // reset state
        smp;
        chk("rst_ready0", req0_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ctrl", alu_ctrl, 0);
        chk("rst_rsp0v", rsp0_valid, 0);
        chk("rst_rsp0r", rsp0_result, 0);
        cyc;
        reset = 1'b0; req0_valid = 1'b0;

        // single add from requester 0
        req0_a = 5; req0_b = 7; req0_op = 3'b000; req0_valid = 1'b1;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        smp;
        chk("add_ready0", req0_ready, 1);
        chk("add_ready1", req1_ready, 0);
        cyc;
        req0_valid = 1'b0;
        smp;
        chk("add_exec_busy", busy, 1);
        chk("add_srca", alu_srca, 5);
        chk("add_srcb", alu_srcb, 7);
        chk("add_exec_rspv", rsp0_valid, 0);
        cyc;
        smp;
        chk("add_rspv", rsp0_valid, 1);
        chk("add_res", rsp0_result, 12);
        chk("add_zero", rsp0_zero, 0);
        chk("add_sign", rsp0_sign, 0);
        chk("add_err", rsp0_err, 0);
        chk("add_rsp1v", rsp1_valid, 0);
        cyc;
        smp;
        chk("add_done_rspv", rsp0_valid, 0);
        chk("add_done_busy", busy, 0);
        cyc;

        // contention from reset
        reset = 1'b1;
        req0_a = 10; req0_b = 10; req0_op = 3'b010; req0_valid = 1'b1;
        req1_a = 1;  req1_b = 4;  req1_op = 3'b001; req1_valid = 1'b1;
        cyc;
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            smp;
            chk($sformatf("cont%0d_ready0", k), req0_ready, (k % 2 == 0));
            chk($sformatf("cont%0d_ready1", k), req1_ready, (k % 2 == 1));
            cyc;
            cyc;
            smp;
            if (k % 2 == 0) begin
                chk($sformatf("cont%0d_rsp0v", k), rsp0_valid, 1);
                chk($sformatf("cont%0d_res0", k), rsp0_result, 0);
                chk($sformatf("cont%0d_zero0", k), rsp0_zero, 1);
            end else begin
                chk($sformatf("cont%0d_rsp1v", k), rsp1_valid, 1);
                chk($sformatf("cont%0d_res1", k), rsp1_result, 16);
                chk($sformatf("cont%0d_zero1", k), rsp1_zero, 0);
            end
            cyc;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // backpressure on requester 1
        req1_a = 32'h8000_0000; req1_b = 0; req1_op = 3'b110; req1_valid = 1'b1;
        rsp1_ready = 1'b0;
        smp;
        chk("bp_ready1", req1_ready, 1);
        cyc;
        req1_valid = 1'b0;
        req0_a = 1; req0_b = 2; req0_op = 3'b000; req0_valid = 1'b1;
        smp;
        chk("bp_exec_ready0", req0_ready, 0);
        cyc;
        for (int k = 0; k < 5; k++) begin
            smp;
            chk($sformatf("bp%0d_rsp1v", k), rsp1_valid, 1);
            chk($sformatf("bp%0d_res", k), rsp1_result, 32'h8000_0000);
            chk($sformatf("bp%0d_sign", k), rsp1_sign, 1);
            chk($sformatf("bp%0d_zero", k), rsp1_zero, 0);
            chk($sformatf("bp%0d_ready0", k), req0_ready, 0);
            cyc;
        end
        rsp1_ready = 1'b1;
        smp;
        chk("bp_hs_rsp1v", rsp1_valid, 1);
        chk("bp_hs_ready0", req0_ready, 0);
        cyc;
        smp;
        chk("bp_after_ready0", req0_ready, 1);
        chk("bp_after_rsp1v", rsp1_valid, 0);
        cyc;
        req0_valid = 1'b0;
        cyc;
        smp;
        chk("bp_req0_res", rsp0_result, 3);
        cyc;

        // illegal op, then a legal one
        req0_a = 3; req0_b = 3; req0_op = 3'b011; req0_valid = 1'b1;
        cyc;
        req0_valid = 1'b0;
        smp;
        chk("ill_ctrl", alu_ctrl, 3'b011);
        cyc;
        smp;
        chk("ill_rspv", rsp0_valid, 1);
        chk("ill_res", rsp0_result, 0);
        chk("ill_zero", rsp0_zero, 1);
        chk("ill_sign", rsp0_sign, 0);
        chk("ill_err", rsp0_err, 1);
        cyc;
        smp;
        chk("ill_err_idle", rsp0_err, 0);
        req0_op = 3'b000; req0_valid = 1'b1;
        cyc;
        req0_valid = 1'b0;
        cyc;
        smp;
        chk("legal_res", rsp0_result, 6);
        chk("legal_err", rsp0_err, 0);
        cyc;

        // reset while in EXEC
        req0_a = 32'hff; req0_b = 32'h0f; req0_op = 3'b111; req0_valid = 1'b1;
        cyc;
        req0_valid = 1'b0;
        smp;
        chk("rx_busy_pre", busy, 1);
        reset = 1'b1;
        #1;
        chk("rx_busy", busy, 0);
        chk("rx_ctrl", alu_ctrl, 0);
        chk("rx_srca", alu_srca, 0);
        chk("rx_rsp0v", rsp0_valid, 0);
        cyc;
        reset = 1'b0;
        smp;
        chk("rx_rsp0v_after", rsp0_valid, 0);
        req0_a = 2; req0_b = 2; req0_op = 3'b000; req0_valid = 1'b1;
        req1_a = 2; req1_b = 2; req1_op = 3'b000; req1_valid = 1'b1;
        #1;
        chk("rx_tie_ready0", req0_ready, 1);
        chk("rx_tie_ready1", req1_ready, 0);
        cyc;
        req0_valid = 1'b0; req1_valid = 1'b0;
        cyc;
        cyc;
        cyc;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
